// File: rtl/tetris_move_ctrl.sv
// Movement controller for the active Tetris piece.
// Spawns pieces, turns MCU commands and gravity ticks into candidate positions,
// asks an external checker for collisions and requests a board write on lock.
// Piece word layout (14 bits): {type[2:0], rot[1:0], x[3:0], y[4:0]}.
module tetris_move_ctrl #(
    parameter logic [3:0] X_SPAWN = 4'd3,
    parameter logic [4:0] Y_SPAWN = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        gravity_tick,
    input  logic [2:0]  spawn_type,
    output logic        chk_req,
    output logic [13:0] chk_piece,
    input  logic        chk_ack,
    input  logic        chk_collide,
    output logic        lock_req,
    input  logic        lock_done,
    output logic [13:0] active,
    output logic        piece_valid,
    output logic        game_over
);

    typedef enum logic [2:0] {
        SPAWN,
        CHK_SPAWN,
        READY,
        CHECK,
        LOCK,
        OVER
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROTATE    = 3'd3,
        CMD_SOFT_DROP = 3'd4
    } command_t;

    state_t     state;
    logic       grav_pend;
    logic       fall;      // candidate came from gravity or soft drop
    logic [1:0] rot;
    logic [3:0] x;
    logic [4:0] y;

    // Field views of the current piece
    always_comb begin
        rot = active[10:9];
        x   = active[8:5];
        y   = active[4:0];
    end

    // Controller FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SPAWN;
            grav_pend   <= 1'b0;
            fall        <= 1'b0;
            active      <= '0;
            chk_piece   <= '0;
            piece_valid <= 1'b0;
            game_over   <= 1'b0;
            cmd_ready   <= 1'b0;
            chk_req     <= 1'b0;
            lock_req    <= 1'b0;
        end else begin
            if (gravity_tick && state != OVER)
                grav_pend <= 1'b1;

            case (state)
                SPAWN: begin
                    chk_piece <= {spawn_type, 2'd0, X_SPAWN, Y_SPAWN};
                    chk_req   <= 1'b1;
                    state     <= CHK_SPAWN;
                end

                CHK_SPAWN: begin
                    if (chk_req && chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_collide) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            active      <= chk_piece;
                            piece_valid <= 1'b1;
                            cmd_ready   <= !(grav_pend || gravity_tick);
                            state       <= READY;
                        end
                    end
                end

                READY: begin
                    if (grav_pend) begin
                        // A tick landing in the same cycle stays pending for the next step
                        grav_pend <= gravity_tick;
                        cmd_ready <= 1'b0;
                        fall      <= 1'b1;
                        if (y == 5'd31) begin
                            lock_req <= 1'b1;
                            state    <= LOCK;
                        end else begin
                            chk_piece <= {active[13:5], y + 5'd1};
                            chk_req   <= 1'b1;
                            state     <= CHECK;
                        end
                    end else if (cmd_valid && cmd_ready) begin
                        // Default: launch a check; rejected/no-op commands override below
                        cmd_ready <= 1'b0;
                        chk_req   <= 1'b1;
                        fall      <= 1'b0;
                        state     <= CHECK;
                        case (cmd)
                            CMD_LEFT: begin
                                chk_piece <= {active[13:9], x - 4'd1, y};
                                if (x == 4'd0) begin
                                    chk_req   <= 1'b0;
                                    cmd_ready <= !gravity_tick;
                                    state     <= READY;
                                end
                            end
                            CMD_RIGHT: begin
                                chk_piece <= {active[13:9], x + 4'd1, y};
                                if (x == 4'd15) begin
                                    chk_req   <= 1'b0;
                                    cmd_ready <= !gravity_tick;
                                    state     <= READY;
                                end
                            end
                            CMD_ROTATE: begin
                                chk_piece <= {active[13:11], rot + 2'd1, active[8:0]};
                            end
                            CMD_SOFT_DROP: begin
                                chk_piece <= {active[13:5], y + 5'd1};
                                fall      <= 1'b1;
                                if (y == 5'd31) begin
                                    chk_req  <= 1'b0;
                                    lock_req <= 1'b1;
                                    state    <= LOCK;
                                end
                            end
                            default: begin
                                chk_req   <= 1'b0;
                                cmd_ready <= !gravity_tick;
                                state     <= READY;
                            end
                        endcase
                    end else begin
                        cmd_ready <= !gravity_tick;
                    end
                end

                CHECK: begin
                    if (chk_req && chk_ack) begin
                        chk_req <= 1'b0;
                        if (chk_collide && fall) begin
                            lock_req <= 1'b1;
                            state    <= LOCK;
                        end else begin
                            if (!chk_collide)
                                active <= chk_piece;
                            cmd_ready <= !(grav_pend || gravity_tick);
                            state     <= READY;
                        end
                    end
                end

                LOCK: begin
                    if (lock_done) begin
                        lock_req    <= 1'b0;
                        piece_valid <= 1'b0;
                        grav_pend   <= 1'b0;
                        state       <= SPAWN;
                    end
                end

                OVER: begin
                end

                default: state <= SPAWN;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Scoreboard bench for tetris_move_ctrl: stimulus pushes expected check/lock
// events, a monitor pops them when chk_req or lock_req rises.
module tb_tetris_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        gravity_tick = 1'b0;
    logic [2:0]  spawn_type = 3'd2;
    logic        chk_req;
    logic [13:0] chk_piece;
    logic        chk_ack = 1'b0;
    logic        chk_collide = 1'b0;
    logic        lock_req;
    logic        lock_done = 1'b0;
    logic [13:0] active;
    logic        piece_valid;
    logic        game_over;

    typedef struct packed {
        logic        is_lock;
        logic [13:0] val;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_chk = 1'b0;
    logic prev_lock = 1'b0;

    localparam logic [2:0] PIECE_T = 3'd2;
    localparam logic [2:0] LEFT = 3'd1, RIGHT = 3'd2, ROTATE = 3'd3, DROP = 3'd4;

    tetris_move_ctrl #(.X_SPAWN(4'd3), .Y_SPAWN(5'd0)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .gravity_tick(gravity_tick), .spawn_type(spawn_type),
        .chk_req(chk_req), .chk_piece(chk_piece), .chk_ack(chk_ack),
        .chk_collide(chk_collide), .lock_req(lock_req), .lock_done(lock_done),
        .active(active), .piece_valid(piece_valid), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic [2:0] t, input logic [1:0] r,
                                       input logic [3:0] x, input logic [4:0] y);
        return {t, r, x, y};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic push(input logic is_lock, input logic [13:0] v);
        exp_t e;
        e.is_lock = is_lock;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic sb_event(input logic is_lock, input logic [13:0] v);
        exp_t e;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_%s: got %h with nothing expected at %0t",
                     is_lock ? "lock_req" : "chk_req", v, $time);
        end else begin
            e = q.pop_front();
            chk(e.is_lock ? "lock_active" : "chk_piece", {17'd0, is_lock, v}, {17'd0, e.is_lock, e.val});
        end
    endtask

    // Monitor: a rising request is one DUT output to compare against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (chk_req && !prev_chk) sb_event(1'b0, chk_piece);
            if (lock_req && !prev_lock) sb_event(1'b1, active);
            prev_chk = chk_req;
            prev_lock = lock_req;
        end
    end

    task automatic ack(input logic collide);
        int n = 0;
        while (!chk_req && n < 20) begin @(negedge clk); n++; end
        if (!chk_req) begin timeout("wait_chk_req"); return; end
        chk_ack = 1'b1;
        chk_collide = collide;
        @(negedge clk);
        chk_ack = 1'b0;
        chk_collide = 1'b0;
        chk("chk_req_drop", {31'd0, chk_req}, 32'd0);
    endtask

    task automatic send(input logic [2:0] c);
        int n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin timeout("wait_cmd_ready"); return; end
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = '0;
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!lock_req && n < 20) begin @(negedge clk); n++; end
        if (!lock_req) timeout("wait_lock_req");
    endtask

    task automatic lock_resp(input int hold);
        wait_lock();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("lock_req_held", {31'd0, lock_req}, 32'd1);
        end
        lock_done = 1'b1;
        @(negedge clk);
        lock_done = 1'b0;
        chk("lock_req_release", {31'd0, lock_req}, 32'd0);
        chk("piece_valid_after_lock", {31'd0, piece_valid}, 32'd0);
    endtask

    task automatic pulse_gravity();
        gravity_tick = 1'b1;
        @(negedge clk);
        gravity_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_active", {18'd0, active}, 32'd0);
        chk("rst_piece_valid", {31'd0, piece_valid}, 32'd0);
        chk("rst_game_over", {31'd0, game_over}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_chk_req", {31'd0, chk_req}, 32'd0);
        chk("rst_lock_req", {31'd0, lock_req}, 32'd0);

        // Spawn
        push(1'b0, pk(PIECE_T, 2'd0, 4'd3, 5'd0));
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!chk_req && n < 2);
        chk("first_chk_req", {31'd0, chk_req}, 32'd1);
        ack(1'b0);
        chk("spawn_active", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd0, 4'd3, 5'd0)});
        chk("spawn_piece_valid", {31'd0, piece_valid}, 32'd1);
        chk("spawn_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Left accepted, then right blocked
        push(1'b0, pk(PIECE_T, 2'd0, 4'd2, 5'd0));
        send(LEFT);
        chk("left_latency_chk_req", {31'd0, chk_req}, 32'd1);
        chk("left_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        ack(1'b0);
        chk("left_active", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd0, 4'd2, 5'd0)});
        chk("left_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        push(1'b0, pk(PIECE_T, 2'd0, 4'd3, 5'd0));
        send(RIGHT);
        ack(1'b1);
        chk("right_blocked_active", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd0, 4'd2, 5'd0)});
        chk("right_blocked_ready", {31'd0, cmd_ready}, 32'd1);
        chk("right_blocked_no_lock", {31'd0, lock_req}, 32'd0);

        // Four rotations wrap to ROT_0
        for (int r = 1; r <= 4; r++) begin
            push(1'b0, pk(PIECE_T, 2'(r), 4'd2, 5'd0));
            send(ROTATE);
            ack(1'b0);
        end
        chk("rotate_wrap", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd0, 4'd2, 5'd0)});

        // Walk to x=0, then a left is rejected locally
        push(1'b0, pk(PIECE_T, 2'd0, 4'd1, 5'd0)); send(LEFT); ack(1'b0);
        push(1'b0, pk(PIECE_T, 2'd0, 4'd0, 5'd0)); send(LEFT); ack(1'b0);
        send(LEFT);
        chk("left_edge_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) begin
            chk("left_edge_no_chk", {31'd0, chk_req}, 32'd0);
            @(negedge clk);
        end
        send(3'd0);
        chk("none_ready", {31'd0, cmd_ready}, 32'd1);
        send(3'd7);
        chk("code7_ready", {31'd0, cmd_ready}, 32'd1);
        chk("noop_active", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd0, 4'd0, 5'd0)});

        // Gravity during CHECK wins over a waiting command
        push(1'b0, pk(PIECE_T, 2'd1, 4'd0, 5'd0));
        send(ROTATE);
        pulse_gravity();
        ack(1'b0);
        chk("grav_pend_blocks_ready", {31'd0, cmd_ready}, 32'd0);
        push(1'b0, pk(PIECE_T, 2'd1, 4'd0, 5'd1));
        push(1'b0, pk(PIECE_T, 2'd1, 4'd1, 5'd1));
        cmd = RIGHT;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("prio_ready_low", {31'd0, cmd_ready}, 32'd0);
        ack(1'b0);
        chk("prio_ready_after_grav", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = '0;
        ack(1'b0);
        chk("prio_active", {18'd0, active}, {18'd0, pk(PIECE_T, 2'd1, 4'd1, 5'd1)});

        // Gravity collision locks, new spawn uses the current spawn_type
        push(1'b0, pk(PIECE_T, 2'd1, 4'd1, 5'd2));
        push(1'b1, pk(PIECE_T, 2'd1, 4'd1, 5'd1));
        spawn_type = 3'd6;
        push(1'b0, pk(3'd6, 2'd0, 4'd3, 5'd0));
        pulse_gravity();
        ack(1'b1);
        lock_resp(3);
        ack(1'b0);
        chk("respawn_active", {18'd0, active}, {18'd0, pk(3'd6, 2'd0, 4'd3, 5'd0)});

        // Right edge at x=15
        for (int i = 4; i <= 15; i++) begin
            push(1'b0, pk(3'd6, 2'd0, 4'(i), 5'd0));
            send(RIGHT);
            ack(1'b0);
        end
        send(RIGHT);
        chk("right_edge_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) begin
            chk("right_edge_no_chk", {31'd0, chk_req}, 32'd0);
            @(negedge clk);
        end

        // Soft drop to the floor, then a drop at y=31 locks directly
        for (int i = 1; i <= 31; i++) begin
            push(1'b0, pk(3'd6, 2'd0, 4'd15, 5'(i)));
            send(DROP);
            ack(1'b0);
        end
        chk("floor_active", {18'd0, active}, {18'd0, pk(3'd6, 2'd0, 4'd15, 5'd31)});
        push(1'b1, pk(3'd6, 2'd0, 4'd15, 5'd31));
        send(DROP);
        chk("floor_direct_lock", {30'd0, lock_req, chk_req}, 32'd2);
        spawn_type = 3'd1;
        push(1'b0, pk(3'd1, 2'd0, 4'd3, 5'd0));
        lock_resp(0);

        // Spawn collision -> game over, all inputs ignored
        ack(1'b1);
        chk("game_over_set", {31'd0, game_over}, 32'd1);
        gravity_tick = 1'b1; cmd_valid = 1'b1; cmd = LEFT; chk_ack = 1'b1; lock_done = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("over_outputs", {28'd0, cmd_ready, chk_req, lock_req, game_over}, 32'd1);
        end
        gravity_tick = 1'b0; cmd_valid = 1'b0; cmd = '0; chk_ack = 1'b0; lock_done = 1'b0;

        // Reset clears game over asynchronously
        #2 rst_n = 1'b0;
        #1 chk("rst_clears_game_over", {31'd0, game_over}, 32'd0);
        push(1'b0, pk(3'd1, 2'd0, 4'd3, 5'd0));
        @(negedge clk);
        rst_n = 1'b1;
        ack(1'b0);

        // Reset in the middle of LOCK
        push(1'b0, pk(3'd1, 2'd0, 4'd3, 5'd1));
        push(1'b1, pk(3'd1, 2'd0, 4'd3, 5'd0));
        pulse_gravity();
        ack(1'b1);
        wait_lock();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midlock_rst_outputs", {28'd0, lock_req, piece_valid, game_over, cmd_ready}, 32'd0);
        chk("midlock_rst_active", {18'd0, active}, 32'd0);
        push(1'b0, pk(3'd1, 2'd0, 4'd3, 5'd0));
        @(negedge clk);
        rst_n = 1'b1;
        ack(1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
